// File: rtl/pipe_adder_tree_pkg.sv
// Shared defaults and sizing helpers for the pipelined adder tree and its levels.
package pipe_adder_tree_pkg;

    localparam int DEF_LANES = 8;
    localparam int DEF_IN_W  = 8;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_BEATS = 32;

    function automatic int tree_lvls(input int lanes);
        return $clog2(lanes);
    endfunction

    // Wide enough to hold the value BEATS itself, not just BEATS-1.
    function automatic int cnt_width(input int beats);
        return $clog2(beats) + 1;
    endfunction

endpackage

// File: rtl/pipe_adder_tree_add_level.sv
// One registered level of the adder tree: N lanes of W bits -> N/2 sums of W+1 bits.
module add_level #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   valid,
    input  logic [N*W-1:0]         data,
    output logic [(N/2)*(W+1)-1:0] sums,
    output logic                   sums_valid
);

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sums_valid <= 1'b0;
        end else begin
            sums_valid <= valid & ~flush;
        end
    end

    // NOTE: datapath flops carry no reset; the valid bit alone says whether they hold a real beat.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N / 2; i++) begin
            sums[i*(W+1) +: (W+1)] <= {1'b0, data[(2*i)*W +: W]} + {1'b0, data[(2*i+1)*W +: W]};
        end
    end

endmodule

// File: rtl/pipe_adder_tree.sv
// Pipelined LANES-wide adder tree feeding a frame accumulator that counts BEATS beats per frame.
module pipe_adder_tree
    import pipe_adder_tree_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int BEATS = DEF_BEATS,
    parameter int CNT_W = cnt_width(BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [LANES*IN_W-1:0] in_data,
    output logic [ACC_W-1:0]      sum,
    output logic                  sum_valid,
    output logic                  done,
    output logic [CNT_W-1:0]      beat_cnt
);

    localparam int TREE_LVLS = tree_lvls(LANES);
    localparam int TREE_W    = IN_W + TREE_LVLS;

    for (genvar k = 0; k < TREE_LVLS; k++) begin : g_lvl
        localparam int N = LANES >> k;
        localparam int W = IN_W + k;

        logic [N*W-1:0]         data;
        logic                   valid;
        logic [(N/2)*(W+1)-1:0] sums;
        logic                   sums_valid;
        logic                   flush;

        // The first level always accepts the incoming beat, even on clear.
        if (k == 0) begin : g_first
            assign data  = in_data;
            assign valid = in_valid;
            assign flush = 1'b0;
        end else begin : g_next
            assign data  = g_lvl[k-1].sums;
            assign valid = g_lvl[k-1].sums_valid;
            assign flush = clear;
        end

        add_level #(.N(N), .W(W)) u_level (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .valid      (valid),
            .data       (data),
            .sums       (sums),
            .sums_valid (sums_valid)
        );
    end

    logic [TREE_W-1:0] tree_out;
    logic              tree_valid;
    logic              frame_full;
    logic [CNT_W-1:0]  next_cnt;

    assign tree_out   = g_lvl[TREE_LVLS-1].sums;
    assign tree_valid = g_lvl[TREE_LVLS-1].sums_valid;
    assign frame_full = (beat_cnt == CNT_W'(BEATS));
    assign next_cnt   = frame_full ? CNT_W'(1) : beat_cnt + CNT_W'(1);

    // A completed frame holds until its successor's first beat, which loads rather than adds.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            sum       <= '0;
            sum_valid <= 1'b0;
            done      <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            sum_valid <= tree_valid;
            done      <= tree_valid && (next_cnt == CNT_W'(BEATS));
            if (tree_valid) begin
                sum      <= frame_full ? ACC_W'(tree_out) : sum + ACC_W'(tree_out);
                beat_cnt <= next_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pipe_adder_tree.sv
// Directed bench for pipe_adder_tree: a frame-level delay-line model checked every cycle, plus literal checks.
module tb_pipe_adder_tree;

    localparam int LANES = 8;
    localparam int IN_W  = 8;
    localparam int BEATS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [63:0] in_data;
    logic [31:0] sum;
    logic        sum_valid;
    logic        done;
    logic [5:0]  beat_cnt;

    logic        w_clear;
    logic        w_valid;
    logic [63:0] w_data;
    logic [15:0] w_sum;
    logic        w_sum_valid;
    logic        w_done;
    logic [6:0]  w_beat_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int sv_cnt   = 0;
    int done_cnt = 0;
    int w_done_cnt = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    pipe_adder_tree dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .sum       (sum),
        .sum_valid (sum_valid),
        .done      (done),
        .beat_cnt  (beat_cnt)
    );

    pipe_adder_tree #(.ACC_W(16), .BEATS(64)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .in_valid  (w_valid),
        .in_data   (w_data),
        .sum       (w_sum),
        .sum_valid (w_sum_valid),
        .done      (w_done),
        .beat_cnt  (w_beat_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        int unsigned val;
    } slot_t;

    slot_t       flight[3];
    int unsigned m_sum;
    int unsigned m_cnt;
    bit          m_sv;
    bit          m_done;

    function automatic int unsigned lane_sum(input logic [63:0] d);
        int unsigned s = 0;
        for (int i = 0; i < LANES; i++) s += d[i*IN_W +: IN_W];
        return s;
    endfunction

    // A beat accepted at an edge reaches the accumulator three edges later.
    always @(posedge clk) begin
        slot_t arriving;
        if (!rst) begin
            m_sum = 0; m_cnt = 0; m_sv = 0; m_done = 0;
            foreach (flight[i]) flight[i] = '{0, 0};
        end else begin
            arriving  = flight[2];
            flight[2] = flight[1];
            flight[1] = flight[0];
            flight[0] = '{in_valid, lane_sum(in_data)};
            m_sv = 0; m_done = 0;
            if (clear) begin
                m_sum = 0; m_cnt = 0;
                flight[1].v = 0; flight[2].v = 0;
            end else if (arriving.v) begin
                if (m_cnt == BEATS) begin
                    m_sum = arriving.val; m_cnt = 1;
                end else begin
                    m_sum += arriving.val; m_cnt++;
                end
                m_sv = 1;
                m_done = (m_cnt == BEATS);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sum", 64'(sum), 64'(m_sum));
            check("sum_valid", 64'(sum_valid), 64'(m_sv));
            check("done", 64'(done), 64'(m_done));
            check("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
            sv_cnt     += int'(sum_valid);
            done_cnt   += int'(done);
            w_done_cnt += int'(w_done);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [7:0] lane, input logic clr);
        @(negedge clk);
        in_valid = v;
        in_data  = {LANES{lane}};
        clear    = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wdrive(input logic v, input logic [7:0] lane);
        @(negedge clk);
        w_valid = v;
        w_data  = {LANES{lane}};
    endtask

    task automatic clr_counts;
        @(posedge clk);
        sv_cnt = 0; done_cnt = 0; w_done_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        w_clear = 1'b0; w_valid = 1'b0; w_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cnt", 64'(beat_cnt), 64'd0);
        check("reset_flags", {62'd0, sum_valid, done}, 64'd0);
        check("reset_w_sum", 64'(w_sum), 64'd0);

        // 1: lanes=1, 32 back-to-back beats
        clr_counts();
        repeat (32) drive(1'b1, 8'h01, 1'b0);
        idle(3);
        check("t1_sum_pre", 64'(sum), 64'd248);
        check("t1_done_pre", 64'(done), 64'd0);
        @(negedge clk);
        check("t1_sum", 64'(sum), 64'd256);
        check("t1_done_at_4", 64'(done), 64'd1);
        check("t1_cnt", 64'(beat_cnt), 64'd32);
        check("t1_model_sum", 64'(m_sum), 64'd256);
        idle(3);
        @(posedge clk);
        check("t1_sv_pulses", 64'(sv_cnt), 64'd32);
        check("t1_done_pulses", 64'(done_cnt), 64'd1);

        // 2: lanes=0xFF, 32 beats; first beat loads a new frame
        clr_counts();
        repeat (32) drive(1'b1, 8'hFF, 1'b0);
        idle(6);
        check("t2_sum", 64'(sum), 64'd65280);
        check("t2_cnt", 64'(beat_cnt), 64'd32);
        check("t2_model_sum", 64'(m_sum), 64'd65280);
        @(posedge clk);
        check("t2_done_pulses", 64'(done_cnt), 64'd1);

        // 3: lanes=2 with alternating bubbles
        clr_counts();
        for (int i = 0; i < 64; i++) drive(i % 2 == 0, 8'h02, 1'b0);
        idle(6);
        check("t3_sum", 64'(sum), 64'd512);
        @(posedge clk);
        check("t3_sv_pulses", 64'(sv_cnt), 64'd32);
        check("t3_done_pulses", 64'(done_cnt), 64'd1);

        // 4: clear arrives with the first beat of a new frame; 7 earlier beats had landed
        clr_counts();
        repeat (10) drive(1'b1, 8'h01, 1'b0);
        drive(1'b1, 8'h03, 1'b1);
        repeat (31) drive(1'b1, 8'h03, 1'b0);
        idle(6);
        check("t4_sum", 64'(sum), 64'd768);
        check("t4_cnt", 64'(beat_cnt), 64'd32);
        check("t4_model_sum", 64'(m_sum), 64'd768);
        @(posedge clk);
        check("t4_sv_pulses", 64'(sv_cnt), 64'd39);
        check("t4_done_pulses", 64'(done_cnt), 64'd1);

        // 5: reset pulse at beat 5 of a frame
        repeat (4) drive(1'b1, 8'h01, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = {LANES{8'h01}}; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        sv_cnt = 0; done_cnt = 0;
        check("t5_sum", 64'(sum), 64'd0);
        check("t5_cnt", 64'(beat_cnt), 64'd0);
        check("t5_flags", {62'd0, sum_valid, done}, 64'd0);
        idle(6);
        @(posedge clk);
        check("t5_no_sv", 64'(sv_cnt), 64'd0);
        check("t5_no_done", 64'(done_cnt), 64'd0);
        drive(1'b1, 8'h02, 1'b0);
        idle(5);
        check("t5_after_sum", 64'(sum), 64'd16);
        check("t5_after_cnt", 64'(beat_cnt), 64'd1);

        // 6: 16-bit accumulator, 64-beat frame, wrap then reload
        clr_counts();
        repeat (64) wdrive(1'b1, 8'hFF);
        repeat (6) wdrive(1'b0, 8'h00);
        check("t6_wrap_sum", 64'(w_sum), 64'hFE00);
        check("t6_cnt", 64'(w_beat_cnt), 64'd64);
        @(posedge clk);
        check("t6_done_pulses", 64'(w_done_cnt), 64'd1);
        wdrive(1'b1, 8'h01);
        repeat (5) wdrive(1'b0, 8'h00);
        check("t6_load_sum", 64'(w_sum), 64'd8);
        check("t6_load_cnt", 64'(w_beat_cnt), 64'd1);

        idle(2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
